// File: rtl/true_dpram_sclk.sv
// true_dpram_sclk: single-clock true dual-port RAM with a post-reset clear sweep
// and deterministic same-address collision handling.
//
// Parameters:
//   WIDTH      data word width
//   ADDRESS    address width, DEPTH = 2**ADDRESS words
//   PRIORITY_A same-address double write: 1 = port A data is stored, 0 = port B
//
// Ports:
//   clk, rst_n               single rising-edge clock, async active-low reset
//   data_in_A/B, addr_A/B    per-port write data and address
//   wr_en_A/B                1 = write, 0 = read
//   data_out_A/B             per-port read data (write-first on own port,
//                            read-first across ports)
//   init_done                high once every word has been cleared
//   collision                one-cycle pulse for a same-address double write
//
// Build option: define TRUE_DPRAM_SCLK_OUT_REG_EN to add an output register
// stage on data_out_A/B and collision (read latency 2 instead of 1).

module true_dpram_sclk #(
  parameter int WIDTH      = 8,
  parameter int ADDRESS    = 6,
  parameter int PRIORITY_A = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   data_in_A,
  input  logic [ADDRESS-1:0] addr_A,
  input  logic               wr_en_A,
  input  logic [WIDTH-1:0]   data_in_B,
  input  logic [ADDRESS-1:0] addr_B,
  input  logic               wr_en_B,
  output logic [WIDTH-1:0]   data_out_A,
  output logic [WIDTH-1:0]   data_out_B,
  output logic               init_done,
  output logic               collision
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]         state;
  logic [ADDRESS-1:0] clr_cnt;
  logic               init_done_r;

  logic [WIDTH-1:0]   mem [0:(2**ADDRESS)-1];

  logic               wa, wb, coll;
  logic               commit_a, commit_b;
  logic [WIDTH-1:0]   win_data;
  logic [WIDTH-1:0]   rd_a, rd_b;
  logic [WIDTH-1:0]   q_a, q_b;
  logic               coll_q;

  // Sweep control. The FSM reaches READY on the edge that clears the last
  // word; init_done follows one edge later, and user accesses are only
  // accepted once init_done is already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= (state == READY);
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + ADDRESS'(1);
        if (clr_cnt == '1) state <= READY;
      end
    end
  end

  assign wa       = init_done_r & wr_en_A;
  assign wb       = init_done_r & wr_en_B;
  assign coll     = wa & wb & (addr_A == addr_B);
  assign win_data = (PRIORITY_A != 0) ? data_in_A : data_in_B;

  // On a same-address double write the losing port's store is suppressed.
  assign commit_a = wa & ~(coll & (PRIORITY_A == 0));
  assign commit_b = wb & ~(coll & (PRIORITY_A != 0));

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (commit_a) mem[addr_A] <= data_in_A;
      if (commit_b) mem[addr_B] <= data_in_B;
    end
  end

  // Read path uses pre-edge memory contents, so a port reading an address the
  // other port writes this cycle sees the old word.
  always_comb begin
    rd_a = mem[addr_A];
    if (wa) rd_a = coll ? win_data : data_in_A;
  end

  always_comb begin
    rd_b = mem[addr_B];
    if (wb) rd_b = coll ? win_data : data_in_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a    <= '0;
      q_b    <= '0;
      coll_q <= 1'b0;
    end else if (!init_done_r) begin
      q_a    <= '0;
      q_b    <= '0;
      coll_q <= 1'b0;
    end else begin
      q_a    <= rd_a;
      q_b    <= rd_b;
      coll_q <= coll;
    end
  end

`ifdef TRUE_DPRAM_SCLK_OUT_REG_EN
  logic [WIDTH-1:0] q2_a, q2_b;
  logic             coll_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2_a    <= '0;
      q2_b    <= '0;
      coll_q2 <= 1'b0;
    end else begin
      q2_a    <= q_a;
      q2_b    <= q_b;
      coll_q2 <= coll_q;
    end
  end

  assign data_out_A = q2_a;
  assign data_out_B = q2_b;
  assign collision  = coll_q2;
`else
  assign data_out_A = q_a;
  assign data_out_B = q_b;
  assign collision  = coll_q;
`endif

  assign init_done = init_done_r;

endmodule

// File: tb/tb_true_dpram_sclk.sv
// Self-checking bench for true_dpram_sclk. Two instances (PRIORITY_A = 1 and 0)
// share all inputs; a reference model computes each access's expected outputs
// when it is driven and queues them for comparison once the read latency has
// elapsed.

module tb_true_dpram_sclk;

`ifdef TRUE_DPRAM_SCLK_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 64;

  logic       clk, rst_n;
  logic [7:0] data_in_A, data_in_B;
  logic [5:0] addr_A, addr_B;
  logic       wr_en_A, wr_en_B;

  logic [7:0] oa1, ob1, oa0, ob0;
  logic       id1, id0, co1, co0;

  true_dpram_sclk #(.WIDTH(8), .ADDRESS(6), .PRIORITY_A(1)) u_pa (
    .clk(clk), .rst_n(rst_n),
    .data_in_A(data_in_A), .addr_A(addr_A), .wr_en_A(wr_en_A),
    .data_in_B(data_in_B), .addr_B(addr_B), .wr_en_B(wr_en_B),
    .data_out_A(oa1), .data_out_B(ob1), .init_done(id1), .collision(co1)
  );

  true_dpram_sclk #(.WIDTH(8), .ADDRESS(6), .PRIORITY_A(0)) u_pb (
    .clk(clk), .rst_n(rst_n),
    .data_in_A(data_in_A), .addr_A(addr_A), .wr_en_A(wr_en_A),
    .data_in_B(data_in_B), .addr_B(addr_B), .wr_en_B(wr_en_B),
    .data_out_A(oa0), .data_out_B(ob0), .init_done(id0), .collision(co0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic [7:0] a1, b1, a0, b0;
    logic       c1, c0;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         edge_cnt = 0;
  logic [7:0] m1 [0:DEPTH-1];
  logic [7:0] m0 [0:DEPTH-1];

  always @(posedge clk) begin
    edge_cnt++;
    #1;
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      e = sb.pop_front();
      chk("sb_due", e.due, edge_cnt);
      chk("out_A_pA", oa1, e.a1);
      chk("out_B_pA", ob1, e.b1);
      chk("coll_pA",  co1, e.c1);
      chk("out_A_pB", oa0, e.a0);
      chk("out_B_pB", ob0, e.b0);
      chk("coll_pB",  co0, e.c0);
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      m1[i] = 8'h00;
      m0[i] = 8'h00;
    end
  endtask

  // One access on both ports, driven at the falling edge.
  task automatic access(input logic wa, input logic [5:0] aa, input logic [7:0] da,
                        input logic wb, input logic [5:0] ab, input logic [7:0] db);
    exp_t x;
    logic c;
    @(negedge clk);
    wr_en_A = wa; addr_A = aa; data_in_A = da;
    wr_en_B = wb; addr_B = ab; data_in_B = db;
    c = wa && wb && (aa == ab);
    x.due = edge_cnt + LAT;
    x.c1 = c;
    x.c0 = c;
    x.a1 = wa ? (c ? da : da) : m1[aa];
    x.b1 = wb ? (c ? da : db) : m1[ab];
    x.a0 = wa ? (c ? db : da) : m0[aa];
    x.b0 = wb ? (c ? db : db) : m0[ab];
    if (c) begin
      m1[aa] = da;
      m0[aa] = db;
    end else begin
      if (wa) begin m1[aa] = da; m0[aa] = da; end
      if (wb) begin m1[ab] = db; m0[ab] = db; end
    end
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en_A = 1'b0;
      wr_en_B = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {oa1, ob1, oa0, ob0}, 32'h0);
    chk({tag, "_flags"}, {id1, co1, id0, co0}, 4'h0);
  endtask

  // Released at a falling edge; counts edges until init_done rises. A write to
  // 0x05 is presented at the second edge of the sweep and must be dropped.
  task automatic sweep(input string tag);
    int  lat;
    bit  bad;
    lat = 0;
    bad = 1'b0;
    for (int n = 1; n <= 200 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        wr_en_A = 1'b1; addr_A = 6'h05; data_in_A = 8'hFF;
      end else if (n == 2) begin
        wr_en_A = 1'b0;
      end
      if ({oa1, ob1, oa0, ob0, co1, co0} != '0) bad = 1'b1;
      if (id1 && id0) lat = n;
      else if (id1 != id0) bad = 1'b1;
    end
    chk({tag, "_init_lat"}, lat, DEPTH + 1);
    chk({tag, "_quiet"}, bad, 0);
    clear_model();
  endtask

  initial begin
    rst_n = 1'b1;
    wr_en_A = 1'b0; wr_en_B = 1'b0;
    addr_A = '0; addr_B = '0; data_in_A = '0; data_in_B = '0;
    clear_model();
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("sweep1");

    // Cleared contents, including the word written during the sweep.
    access(1'b0, 6'h00, 8'h00, 1'b0, 6'h28, 8'h00);
    access(1'b0, 6'h3F, 8'h00, 1'b0, 6'h3F, 8'h00);
    access(1'b0, 6'h05, 8'h00, 1'b0, 6'h05, 8'h00);

    // Independent writes, then cross reads.
    access(1'b1, 6'h28, 8'hB5, 1'b1, 6'h3D, 8'h6F);
    access(1'b0, 6'h3D, 8'h00, 1'b0, 6'h28, 8'h00);

    // Double write to one address, then read back.
    access(1'b1, 6'h10, 8'hAA, 1'b1, 6'h10, 8'h55);
    access(1'b0, 6'h10, 8'h00, 1'b0, 6'h10, 8'h00);

    // Cross-port read during write.
    access(1'b1, 6'h20, 8'h11, 1'b0, 6'h00, 8'h00);
    access(1'b1, 6'h20, 8'h22, 1'b0, 6'h20, 8'h00);
    access(1'b0, 6'h20, 8'h00, 1'b0, 6'h20, 8'h00);

    // Mixed traffic over a narrow address window to provoke collisions.
    for (int i = 0; i < 24; i++) begin
      access(1'($urandom_range(0, 1)), 6'(8 + $urandom_range(0, 3)), 8'($urandom),
             1'($urandom_range(0, 1)), 6'(8 + $urandom_range(0, 3)), 8'($urandom));
    end
    drain();

    // Mid-operation reset: hold a read of live data, then reset asynchronously.
    access(1'b0, 6'h28, 8'h00, 1'b0, 6'h3D, 8'h00);
    drain();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_midop");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Abort that sweep at its 20th cycle.
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_midsweep");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep("sweep2");

    access(1'b0, 6'h28, 8'h00, 1'b0, 6'h3D, 8'h00);
    access(1'b0, 6'h10, 8'h00, 1'b0, 6'h20, 8'h00);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
